guess_sched: RTL and testbench

Controller sequencing the receive path (UART receiver feeding the guess buffer) into the game logic. Gates the receiver with `rec_ready`, validates each received byte as a letter guess, rejects repeats using a 26-bit used-letter mask, and offers each accepted guess to the game with a valid/ack handshake while driving `game_rdy` to the buffer. Sits between the receive path and the hangman game FSM on the receiving board.

---
 rtl/guess_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_guess_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_sched.sv
// ============================================================================
// guess_sched
//
// Sequences the receive path (UART receiver + guess buffer) into the hangman
// game FSM. The receiver is enabled with rec_ready only while listening. Each
// received byte is classified as a letter guess and checked against the
// 26-bit used-letter mask. Fresh letters are offered to the game with a
// valid/ack handshake; game_rdy releases the guess buffer for the same span.
//
// Build option:
//   GUESS_CASE_FOLD_EN  - when defined, lowercase 'a'..'z' fold onto
//                         'A'..'Z' and share their mask bit; otherwise
//                         lowercase bytes are rejected as bad.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_ready        one-cycle strobe, rx_byte valid
//   rx_byte[7:0]    received ASCII byte
//   rx_err          one-cycle framing-error strobe
//   new_game        one-cycle strobe, clear all game history
//   game_ack        game consumed the offered guess
//   rec_ready       receiver enable (high only while listening)
//   game_rdy        buffer release strobe, same as guess_valid
//   guess_valid     guess offered to the game
//   guess_ascii     accepted guess, uppercase ASCII
//   guess_idx       letter index 0 (A) .. 25 (Z)
//   bad_pulse       one cycle: byte is not a legal letter
//   dup_pulse       one cycle: letter already used
//   overrun_pulse   one cycle: byte arrived while not listening
//   err_led         sticky framing-error indicator
//   used_mask       bit i set = letter i already accepted
//   guess_cnt       number of accepted guesses (saturates at 26)
// ============================================================================
module guess_sched #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_ready,
    input  logic [7:0]       rx_byte,
    input  logic             rx_err,
    input  logic             new_game,
    input  logic             game_ack,
    output logic             rec_ready,
    output logic             game_rdy,
    output logic             guess_valid,
    output logic [7:0]       guess_ascii,
    output logic [4:0]       guess_idx,
    output logic             bad_pulse,
    output logic             dup_pulse,
    output logic             overrun_pulse,
    output logic             err_led,
    output logic [25:0]      used_mask,
    output logic [CNT_W-1:0] guess_cnt
);

    typedef enum logic [1:0] {
        ST_LISTEN = 2'd0,
        ST_CHECK  = 2'd1,
        ST_OFFER  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(5'd26);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(5'd1);

    // Returns {legal, idx}. Both letter ranges start at low-5-bits == 1,
    // so the index is simply the low five bits minus one.
    function automatic logic [5:0] classify(input logic [7:0] b);
        logic [5:0] r;
        r = 6'd0;
        if ((b >= 8'h41) && (b <= 8'h5A)) begin
            r = {1'b1, b[4:0] - 5'd1};
        end
`ifdef GUESS_CASE_FOLD_EN
        else if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = {1'b1, b[4:0] - 5'd1};
        end
`endif
        else begin
            r = 6'd0;
        end
        return r;
    endfunction

    function automatic logic [25:0] onehot26(input logic [4:0] idx);
        return 26'd1 << idx;
    endfunction

    state_t             state_r, state_next_s;
    logic [4:0]         held_idx_r, held_idx_next_s;
    logic               held_fresh_r, held_fresh_next_s;
    logic               rec_ready_r, rec_ready_next_s;
    logic               valid_r, valid_next_s;
    logic [7:0]         ascii_r, ascii_next_s;
    logic [4:0]         idx_r, idx_next_s;
    logic               bad_r, bad_next_s;
    logic               dup_r, dup_next_s;
    logic               overrun_r, overrun_next_s;
    logic               err_r, err_next_s;
    logic [25:0]        mask_r, mask_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;

    logic [5:0]         cls_s;
    logic               rx_used_s;

    // Classify the incoming byte while listening so reject pulses land in CHECK.
    always_comb begin
        cls_s     = classify(rx_byte);
        rx_used_s = |(mask_r & onehot26(cls_s[4:0]));
    end

    // Next-state and next-output computation for every register.
    always_comb begin
        state_next_s      = state_r;
        held_idx_next_s   = held_idx_r;
        held_fresh_next_s = held_fresh_r;
        valid_next_s      = valid_r;
        ascii_next_s      = ascii_r;
        idx_next_s        = idx_r;
        bad_next_s        = 1'b0;
        dup_next_s        = 1'b0;
        overrun_next_s    = 1'b0;
        err_next_s        = err_r | rx_err;
        mask_next_s       = mask_r;
        cnt_next_s        = cnt_r;

        case (state_r)
            ST_LISTEN: begin
                if (rx_ready) begin
                    held_idx_next_s   = cls_s[4:0];
                    held_fresh_next_s = cls_s[5] & ~rx_used_s;
                    bad_next_s        = ~cls_s[5];
                    dup_next_s        = cls_s[5] & rx_used_s;
                    state_next_s      = ST_CHECK;
                end else begin
                    state_next_s      = ST_LISTEN;
                end
            end
            ST_CHECK: begin
                overrun_next_s = rx_ready;
                if (held_fresh_r) begin
                    mask_next_s  = mask_r | onehot26(held_idx_r);
                    if (cnt_r != CNT_MAX) begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                    ascii_next_s = 8'h41 + {3'b000, held_idx_r};
                    idx_next_s   = held_idx_r;
                    valid_next_s = 1'b1;
                    state_next_s = ST_OFFER;
                end else begin
                    state_next_s = ST_LISTEN;
                end
            end
            ST_OFFER: begin
                overrun_next_s = rx_ready;
                if (game_ack) begin
                    valid_next_s = 1'b0;
                    state_next_s = ST_LISTEN;
                end else begin
                    valid_next_s = 1'b1;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                state_next_s = ST_LISTEN;
            end
        endcase

        // new_game wins over everything else in the same cycle, including
        // the mask bit of an offer that is being dropped.
        if (new_game) begin
            state_next_s      = ST_LISTEN;
            held_fresh_next_s = 1'b0;
            valid_next_s      = 1'b0;
            bad_next_s        = 1'b0;
            dup_next_s        = 1'b0;
            overrun_next_s    = 1'b0;
            err_next_s        = 1'b0;
            mask_next_s       = 26'd0;
            cnt_next_s        = '0;
        end else begin
            held_fresh_next_s = held_fresh_next_s;
        end

        rec_ready_next_s = (state_next_s == ST_LISTEN);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LISTEN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_idx_r   <= 5'd0;
            held_fresh_r <= 1'b0;
            rec_ready_r  <= 1'b1;
            valid_r      <= 1'b0;
            ascii_r      <= 8'h00;
            idx_r        <= 5'd0;
            bad_r        <= 1'b0;
            dup_r        <= 1'b0;
            overrun_r    <= 1'b0;
            err_r        <= 1'b0;
            mask_r       <= 26'd0;
            cnt_r        <= '0;
        end else begin
            held_idx_r   <= held_idx_next_s;
            held_fresh_r <= held_fresh_next_s;
            rec_ready_r  <= rec_ready_next_s;
            valid_r      <= valid_next_s;
            ascii_r      <= ascii_next_s;
            idx_r        <= idx_next_s;
            bad_r        <= bad_next_s;
            dup_r        <= dup_next_s;
            overrun_r    <= overrun_next_s;
            err_r        <= err_next_s;
            mask_r       <= mask_next_s;
            cnt_r        <= cnt_next_s;
        end
    end

    assign rec_ready     = rec_ready_r;
    assign guess_valid   = valid_r;
    assign game_rdy      = valid_r;
    assign guess_ascii   = ascii_r;
    assign guess_idx     = idx_r;
    assign bad_pulse     = bad_r;
    assign dup_pulse     = dup_r;
    assign overrun_pulse = overrun_r;
    assign err_led       = err_r;
    assign used_mask     = mask_r;
    assign guess_cnt     = cnt_r;

endmodule

// File: tb/tb_guess_sched.sv
// Scoreboard bench for guess_sched: stimulus pushes expected events (offer,
// bad, dup, overrun) with their expected cycle; a negedge monitor pops and
// compares whenever the DUT presents one of those events.
module tb_guess_sched;

    localparam int CNT_W = 5;
    localparam int K_OFFER = 0;
    localparam int K_BAD   = 1;
    localparam int K_DUP   = 2;
    localparam int K_OVR   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_ready = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             rx_err = 1'b0;
    logic             new_game = 1'b0;
    logic             game_ack = 1'b0;
    logic             rec_ready, game_rdy, guess_valid;
    logic [7:0]       guess_ascii;
    logic [4:0]       guess_idx;
    logic             bad_pulse, dup_pulse, overrun_pulse, err_led;
    logic [25:0]      used_mask;
    logic [CNT_W-1:0] guess_cnt;

    guess_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_byte(rx_byte),
        .rx_err(rx_err), .new_game(new_game), .game_ack(game_ack),
        .rec_ready(rec_ready), .game_rdy(game_rdy), .guess_valid(guess_valid),
        .guess_ascii(guess_ascii), .guess_idx(guess_idx),
        .bad_pulse(bad_pulse), .dup_pulse(dup_pulse),
        .overrun_pulse(overrun_pulse), .err_led(err_led),
        .used_mask(used_mask), .guess_cnt(guess_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [7:0]  ascii;
        logic [4:0]  idx;
        logic [25:0] mask;
        logic [4:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [25:0] exp_mask = 26'd0;
    logic [4:0]  exp_cnt = 5'd0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [7:0] a, input logic [4:0] i, input int dcyc);
        exp_t e;
        e.kind = kind; e.ascii = a; e.idx = i;
        e.mask = exp_mask; e.cnt = exp_cnt; e.cyc = cyc + dcyc;
        sb_q.push_back(e);
    endtask

    task automatic mon_event(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_event_kind", kind, 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_OFFER) begin
                chk("offer_ascii", guess_ascii, e.ascii);
                chk("offer_idx", guess_idx, e.idx);
                chk("offer_mask", used_mask, e.mask);
                chk("offer_cnt", guess_cnt, e.cnt);
                chk("offer_game_rdy", game_rdy, 1);
                chk("offer_rec_ready", rec_ready, 0);
            end
        end
    endtask

    // Monitor: sample away from the active edge and score every DUT event.
    always @(negedge clk) begin
        if (!rst) begin
            if (guess_valid && !prev_valid) mon_event(K_OFFER);
            if (bad_pulse)     mon_event(K_BAD);
            if (dup_pulse)     mon_event(K_DUP);
            if (overrun_pulse) mon_event(K_OVR);
        end
        prev_valid = guess_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_byte = b; rx_ready = 1'b1; rx_err = err;
        tick();
        rx_ready = 1'b0; rx_err = 1'b0;
    endtask

    task automatic wait_offer();
        for (int k = 0; k < 8; k++) begin
            if (guess_valid) break;
            tick();
        end
        chk("offer_timeout", guess_valid, 1);
    endtask

    task automatic ack();
        game_ack = 1'b1;
        tick();
        game_ack = 1'b0;
        chk("ack_rec_ready", rec_ready, 1);
        chk("ack_valid_low", guess_valid, 0);
    endtask

    task automatic offer_letter(input logic [7:0] b, input logic [7:0] up, input logic [4:0] i, input logic err);
        exp_mask = exp_mask | (26'd1 << i);
        if (exp_cnt != 5'd26) exp_cnt = exp_cnt + 5'd1;
        push_exp(K_OFFER, up, i, 2);
        send(b, err);
        wait_offer();
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        // Reset state
        chk("rst_rec_ready", rec_ready, 1);
        chk("rst_valid", {game_rdy, guess_valid}, 0);
        chk("rst_ascii_idx", {guess_ascii, 3'b000, guess_idx}, 0);
        chk("rst_pulses_err", {bad_pulse, dup_pulse, overrun_pulse, err_led}, 0);
        chk("rst_mask_cnt", {used_mask, guess_cnt}, 0);

        // Stray ack while idle is ignored
        game_ack = 1'b1; tick(); game_ack = 1'b0;
        chk("idle_ack_rec_ready", rec_ready, 1);

        // 'H' accepted, held for two extra cycles, then acked
        exp_mask = 26'h80; exp_cnt = 5'd1;
        push_exp(K_OFFER, 8'h48, 5'd7, 2);
        send(8'h48, 1'b0);
        chk("check_rec_ready_low", rec_ready, 0);
        wait_offer();
        tick(); tick();
        chk("offer_hold_valid", guess_valid, 1);
        chk("offer_hold_ascii", guess_ascii, 8'h48);
        ack();

        // Duplicate 'H'
        push_exp(K_DUP, 8'h00, 5'd0, 1);
        send(8'h48, 1'b0);
        tick();
        chk("dup_pulse_width", dup_pulse, 0);
        chk("dup_cnt", guess_cnt, 1);
        chk("dup_no_valid", guess_valid, 0);
        chk("dup_rec_ready", rec_ready, 1);

        // Non-letter '1'
        push_exp(K_BAD, 8'h00, 5'd0, 1);
        send(8'h31, 1'b0);
        tick();
        chk("bad_pulse_width", bad_pulse, 0);

        // Lowercase 'e'
`ifdef GUESS_CASE_FOLD_EN
        offer_letter(8'h65, 8'h45, 5'd4, 1'b0);
`else
        push_exp(K_BAD, 8'h00, 5'd0, 1);
        send(8'h65, 1'b0);
        tick();
`endif
        chk("after_e_cnt", guess_cnt, exp_cnt);

        // new_game and game_ack together while offering 'Q'
        exp_mask = exp_mask | 26'h1_0000;
        exp_cnt = exp_cnt + 5'd1;
        push_exp(K_OFFER, 8'h51, 5'd16, 2);
        send(8'h51, 1'b0);
        wait_offer();
        new_game = 1'b1; game_ack = 1'b1;
        tick();
        new_game = 1'b0; game_ack = 1'b0;
        exp_mask = 26'd0; exp_cnt = 5'd0;
        chk("ng_rec_ready", rec_ready, 1);
        chk("ng_valid", guess_valid, 0);
        chk("ng_mask", used_mask, 0);
        chk("ng_cnt", guess_cnt, 0);

        // 'H' again accepted; overrun with 'Z' while offering
        exp_mask = 26'h80; exp_cnt = 5'd1;
        push_exp(K_OFFER, 8'h48, 5'd7, 2);
        send(8'h48, 1'b0);
        wait_offer();
        push_exp(K_OVR, 8'h00, 5'd0, 1);
        send(8'h5A, 1'b0);
        chk("ovr_valid_held", guess_valid, 1);
        chk("ovr_ascii_held", guess_ascii, 8'h48);
        chk("ovr_bit25_clear", used_mask[25], 0);
        tick();
        chk("ovr_pulse_width", overrun_pulse, 0);
        ack();

        // Framing error is sticky
        rx_err = 1'b1; tick(); rx_err = 1'b0;
        chk("err_led_set", err_led, 1);
        chk("err_rec_ready", rec_ready, 1);

        // All remaining letters; first one arrives with a coincident rx_err
        for (int i = 0; i < 26; i++) begin
            logic [7:0] up;
            up = 8'h41 + 8'(i);
            if (i != 7) offer_letter(up, up, 5'(i), (i == 0));
        end
        chk("all_mask", used_mask, 26'h3FF_FFFF);
        chk("all_cnt", guess_cnt, 26);
        chk("all_err_led", err_led, 1);

        // Any further letter is a duplicate
        push_exp(K_DUP, 8'h00, 5'd0, 1);
        send(8'h4D, 1'b0);
        tick();
        chk("full_cnt", guess_cnt, 26);

        // new_game clears history and the error indicator
        new_game = 1'b1; tick(); new_game = 1'b0;
        chk("ng2_err_led", err_led, 0);
        chk("ng2_mask_cnt", {used_mask, guess_cnt}, 0);

        repeat (3) tick();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
